// File: rtl/tbs_pkg.sv
// Shared types and defaults for the TBS transmit path.
// TBS_TX_PARITY_EN selects 8E1 framing (11 bit periods) instead of 8N1 (10 bit periods).
package tbs_pkg;

  localparam int TBS_BIT_PERIOD = 434;
  localparam int TBS_PULSE      = 54;

`ifdef TBS_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } tbs_state_t;

  // Frame image, LSB transmitted first: start(0), d0..d7, [parity], stop(1).
  function automatic logic [FRAME_BITS-1:0] tbs_frame(input logic [7:0] data);
`ifdef TBS_TX_PARITY_EN
    return {1'b1, ^data, data, 1'b0};
`else
    return {1'b1, data, 1'b0};
`endif
  endfunction

endpackage

// File: rtl/tbs_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap.
module tbs_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  int               idx;
  logic [IDX_W-1:0] ix;

  // Walk the priority order from lowest to highest priority so the closest
  // valid requester to rr_ptr is the last one written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    ix        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      ix = IDX_W'(idx);
      if (req_valid[ix]) begin
        grant     = '0;
        grant[ix] = 1'b1;
        grant_idx = ix;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbs_tx_arbiter.sv
// Round-robin byte arbiter driving the single-wire TBS line (UART frame, '0' bits as short low pulses).
// Build option: TBS_TX_PARITY_EN adds an even-parity bit before stop.
//
// state | meaning
// IDLE  | line high, arbitrating; a valid request transfers on this edge
// SEND  | shifting FRAME_BITS bit periods out of frame_sr
// GUARD | line high for GUARD_BITS bit periods before the next grant
module tbs_tx_arbiter
  import tbs_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int BIT_PERIOD_COUNT = TBS_BIT_PERIOD,
  parameter int PULSE_COUNT      = TBS_PULSE,
  parameter int GUARD_BITS       = 2
) (
  input  logic                       clk_50M,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       TBS_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PER_W = $clog2(BIT_PERIOD_COUNT);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(BIT_PERIOD_COUNT - 1);
  localparam logic [PER_W-1:0] PULSE_END  = PER_W'(PULSE_COUNT);
  localparam logic [3:0]       FRAME_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0]       GUARD_LAST = 4'(GUARD_BITS - 1);

  tbs_state_t            state;
  logic [PER_W-1:0]      per_cnt;
  logic [PER_W-1:0]      per_nxt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] frame_sr;
  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [7:0]            sel_byte;

  tbs_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  assign req_ready = (state == IDLE) ? arb_grant : '0;
  assign busy      = (state != IDLE);
  assign per_nxt   = per_cnt + PER_W'(1);

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_byte = sel_byte | req_data[i*8 +: 8];
    end
  end

  // TBS_out is computed from the next counter values so the line tracks
  // per_cnt/frame_sr with no extra pipeline cycle.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      per_cnt  <= '0;
      bit_cnt  <= '0;
      frame_sr <= '1;
      rr_ptr   <= '0;
      grant_id <= '0;
      TBS_out  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          TBS_out <= 1'b1;
          if (arb_any) begin
            frame_sr <= tbs_frame(sel_byte);
            grant_id <= arb_idx;
            rr_ptr   <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            per_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SEND;
            TBS_out  <= 1'b0;  // start bit pulse begins immediately
          end
        end
        SEND: begin
          if (per_cnt == PER_LAST) begin
            per_cnt  <= '0;
            frame_sr <= {1'b1, frame_sr[FRAME_BITS-1:1]};
            if (bit_cnt == FRAME_LAST) begin
              bit_cnt <= '0;
              state   <= GUARD;
              TBS_out <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              TBS_out <= frame_sr[1];
            end
          end else begin
            per_cnt <= per_nxt;
            TBS_out <= ~((per_nxt < PULSE_END) & ~frame_sr[0]);
          end
        end
        GUARD: begin
          TBS_out <= 1'b1;
          if (per_cnt == PER_LAST) begin
            per_cnt <= '0;
            if (bit_cnt == GUARD_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            per_cnt <= per_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          TBS_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/tbs_tx_arbiter.md
Name: tbs_tx_arbiter

Overview:
Shares the single-wire TBS transmit line between NUM_REQ byte sources using round-robin arbitration.
- Each granted byte is framed as UART 8N1, LSB first.
- Each frame is TBS-encoded: every '0' bit is a short low pulse at the start of its bit period; every '1' bit leaves the line high.
- The matching TBS receiver stretches each pulse back into a full-period low bit for the downstream UART receiver.
- This block sits between the system byte producers (command/status sources) and the TBS pad.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- BIT_PERIOD_COUNT, 434: clocks per bit period (50 MHz / 115200).
- PULSE_COUNT, 54: low-pulse width in clocks for a '0' bit. Must be less than BIT_PERIOD_COUNT.
- GUARD_BITS, 2: idle-high bit periods inserted after every frame before the next grant.

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe (combinational).
- TBS_out  out  1  TBS line drive, registered, idle high.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.

Behaviour:
- Reset values: TBS_out=1, busy=0, grant_id=0, rr_ptr=0, state=IDLE, counters=0. req_ready=0 (state is not IDLE-eligible until a valid arrives).
- States and transitions:
  - IDLE: when any request is valid, go to SEND.
  - SEND: runs for FRAME_BITS bit periods, then goes to GUARD.
  - GUARD: runs for GUARD_BITS bit periods, then goes to IDLE.
- Arbitration in IDLE:
  - Search upward from rr_ptr with modulo-NUM_REQ wrap; the first i with req_valid[i]=1 wins.
  - req_ready[i]=1 only for the winner, only in IDLE. The transfer happens on that clock edge.
  - On transfer: latch the byte into a shift register, set grant_id=i, set rr_ptr=(i+1) mod NUM_REQ, enter SEND.
- Frame format: FRAME_BITS=10, sent as start(0), d0..d7, stop(1).
- Per bit, a bit counter (bit_cnt) and a bit-period counter (per_cnt, 0..BIT_PERIOD_COUNT-1) run together:
  - TBS_out=0 while per_cnt<PULSE_COUNT and the current bit is 0; otherwise TBS_out=1.
  - When per_cnt wraps, advance to the next bit.
- Latency: TBS_out falls on the first cycle after the transfer edge (1 clock). A frame occupies exactly 10*BIT_PERIOD_COUNT cycles of SEND.
- GUARD: TBS_out held at 1 for GUARD_BITS*BIT_PERIOD_COUNT cycles, then return to IDLE. The earliest next transfer is on the first IDLE cycle.
- Back-to-back requests: requester-to-requester spacing is exactly (10+GUARD_BITS)*BIT_PERIOD_COUNT+1 cycles. The +1 is the IDLE arbitration cycle.
- A request deasserted before it is granted is dropped silently. req_valid is ignored outside IDLE, and the latched byte is immune to later req_data changes.
- Simultaneous valid on all inputs with rr_ptr=k: grants run in the order k, k+1, ... with wrap.
- Reset mid-frame: TBS_out returns to 1 immediately (asynchronously). The partial frame is abandoned and never resumed.
- Counter widths: $clog2(BIT_PERIOD_COUNT) bits for per_cnt; 4 bits for bit_cnt.

Optional Feature:
- Macro: TBS_TX_PARITY_EN.
- When defined: FRAME_BITS=11. An even-parity bit (XOR of d0..d7) is inserted between d7 and stop. Frame time is 11 bit periods.
- When not defined: 8N1 framing, 10 bit periods, with no parity logic synthesized.

Decomposition:
- Shared package tbs_pkg holds:
  - the TBS_BIT_PERIOD and TBS_PULSE defaults;
  - the state encoding typedef (IDLE, SEND, GUARD);
  - the FRAME_BITS localparam, selected by the macro.
- One natural sub-module: tbs_rr_arbiter, a combinational round-robin picker.
  - Inputs: req_valid, rr_ptr.
  - Outputs: one-hot grant, grant index, any_valid.
- The frame serializer and pulse shaper stay in the top module.

Test Plan:
- After reset with no requests: TBS_out=1, busy=0, req_ready=0 for 10,000 cycles.
- Single byte 0x55 from req 2: req_ready[2] pulses once. Lows appear at bit periods 0,2,4,6,8, each exactly 54 cycles wide. grant_id=2, and busy drops 12*434 cycles later.
- Loopback: byte 0xA3 through tbs_tx_arbiter into the TBS receiver. A UART monitor on the receiver output decodes 0xA3 with a correct stop bit.
- All four valid from reset, 0x11/0x22/0x33/0x44: grant order is 0,1,2,3. Consecutive req_ready pulses are exactly 12*434+1 cycles apart.
- Arbitration and data hold: rr_ptr=3 with req 0 and req 3 valid grants 3 then 0. Changing req_data[3] mid-frame does not alter the transmitted bits.
- Reset mid-frame, asserted at bit 4 of 0x00: TBS_out=1 within the same cycle and busy=0. After release, a new request transmits cleanly.
- With TBS_TX_PARITY_EN, byte 0x07: parity bit=1 (no pulse), frame length is 11 periods.
